// File: rtl/cmd_assembler.sv
// rtl/cmd_assembler.sv - SUMP command assembler: byte stream to opcode/config_data/execute (optional CMD_TIMEOUT_EN)
module cmd_assembler #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TIMEOUT_WIDTH  = 17
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [7:0]  opcode,
    output logic [31:0] config_data,
    output logic        execute,
    output logic        cmd_pending,
    output logic        timeout_err
);

    typedef enum logic {IDLE = 1'b0, ARGS = 1'b1} state_t;

    if ((2.0 ** TIMEOUT_WIDTH) <= TIMEOUT_CYCLES) begin : g_bad_width
        $error("TIMEOUT_WIDTH too small for TIMEOUT_CYCLES");
    end

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic [31:0] arg_q, arg_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [31:0] config_q, config_d;
    logic        exec_q, exec_d;
    logic        tmo_hit;

`ifdef CMD_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tcnt_q, tcnt_d;
    logic                     tmo_q, tmo_d;

    // A byte in the final counter cycle is accepted instead of timing out.
    assign tmo_hit = (state_q == ARGS) && !rx_valid
                     && (tcnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tcnt_d = '0;
        tmo_d  = tmo_hit;
        if (state_q == ARGS && !rx_valid && !tmo_hit) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end

    assign timeout_err = tmo_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hold_q   <= '0;
            arg_q    <= '0;
            opcode_q <= '0;
            config_q <= '0;
            exec_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            arg_q    <= arg_d;
            opcode_q <= opcode_d;
            config_q <= config_d;
            exec_q   <= exec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (rx_valid && rx_data[7]) state_d = ARGS;
            ARGS: begin
                if (rx_valid && cnt_q == 2'd3) state_d = IDLE;
                else if (tmo_hit)              state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        arg_d    = arg_q;
        opcode_d = opcode_q;
        config_d = config_q;
        exec_d   = 1'b0;
        if (rx_valid) begin
            if (state_q == IDLE) begin
                if (!rx_data[7]) begin
                    opcode_d = rx_data;
                    config_d = '0;
                    exec_d   = 1'b1;
                end else begin
                    hold_d = rx_data;
                    arg_d  = '0;
                    cnt_d  = '0;
                end
            end else begin
                // Argument bytes arrive little-endian; bit7 carries no meaning here.
                arg_d[8*cnt_q +: 8] = rx_data;
                cnt_d               = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    opcode_d = hold_q;
                    config_d = {rx_data, arg_q[23:0]};
                    exec_d   = 1'b1;
                end
            end
        end
    end

    assign opcode      = opcode_q;
    assign config_data = config_q;
    assign execute     = exec_q;
    assign cmd_pending = (state_q == ARGS);

endmodule

// File: doc/cmd_assembler.md
Name: cmd_assembler

Overview:
- Upstream neighbour of the analyzer core: converts the byte stream from the serial/SPI receiver into SUMP commands.
- Each command is presented to the core as opcode, config_data and a one-cycle execute pulse.
- Opcode bit7=0: short command (1 byte total).
- Opcode bit7=1: long command (opcode followed by 4 argument bytes, little-endian).

Parameters:
- TIMEOUT_CYCLES, 100000, clock cycles allowed between argument bytes before a partial long command is discarded (used only with CMD_TIMEOUT_EN).
- TIMEOUT_WIDTH, 17, counter width; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clock  input  1  core clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rx_valid  input  1  rx_data holds a new byte this cycle (single-cycle strobe, no backpressure).
- rx_data  input  8  received byte.
- opcode  output  8  command opcode, registered.
- config_data  output  32  command argument, registered; 0 for short commands.
- execute  output  1  one-cycle pulse; opcode/config_data valid.
- cmd_pending  output  1  high while a long command is partially received.
- timeout_err  output  1  one-cycle pulse when a partial command is discarded.

Behaviour:
- Reset: all outputs and internal state cleared.
  - opcode=0, config_data=0, execute=0, cmd_pending=0, timeout_err=0.
  - FSM=IDLE, byte count=0, timeout counter=0.
- Every rx_valid byte is accepted; there is no stall path.
- IDLE:
  - On rx_valid with rx_data[7]=0: next cycle opcode<=rx_data, config_data<=0, execute=1. FSM stays IDLE.
  - On rx_valid with rx_data[7]=1: latch rx_data into a holding opcode register, clear the argument shift register, set cnt=0, go to ARGS. cmd_pending=1 from the next cycle.
- ARGS:
  - Each rx_valid writes byte k (k=cnt) into arg[8k+7:8k] and increments cnt. First argument byte goes to config_data[7:0].
  - On the 4th byte (cnt=3): next cycle opcode<=held opcode, config_data<=assembled word, execute=1, cmd_pending=0, FSM=IDLE.
  - Argument bytes are taken as data regardless of bit7.
- Latency: execute rises exactly 1 cycle after the cycle in which the final byte of a command is accepted.
- execute is high for exactly 1 cycle per command.
- opcode/config_data hold their values until the next execute; they change only in the execute cycle.
- Back-to-back: a byte arriving in the same cycle execute is high is processed normally as the first byte of the next command. No byte is lost; consecutive execute pulses are allowed.
- Reset mid-command: the partial command is discarded, no execute is issued, and the FSM restarts in IDLE on the next byte.
- The SUMP reset sequence (0x00 ×5) yields five short-command executes with opcode 0x00. In ARGS, 0x00 bytes are argument data; the host's 5× repetition resynchronises the stream.

Optional Feature:
- Macro CMD_TIMEOUT_EN.
- Defined:
  - In ARGS, the counter increments each cycle without rx_valid and clears on each accepted byte.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rx_valid, the next cycle returns to IDLE: cmd_pending=0, timeout_err=1 for 1 cycle, no execute, outputs unchanged.
  - An rx_valid in that final cycle wins over the timeout.
- Not defined:
  - No counter is built; timeout_err is tied 0.
  - ARGS waits indefinitely.

Test Plan:
- Short command: reset, send 0x02 → one cycle later opcode=0x02, config_data=0x00000000, execute=1 for 1 cycle, cmd_pending stays 0.
- Long command: send 0xC0,0x11,0x22,0x33,0x44 with gaps of 0–7 idle cycles → single execute with opcode=0xC0, config_data=0x44332211. cmd_pending high from the cycle after 0xC0 until the execute cycle.
- Back-to-back: 0x80,0x01,0x00,0x00,0x00 immediately followed by 0x01 on consecutive cycles → execute(0x80, 0x00000001), then execute(0x01, 0) on the very next cycle. Outputs hold between executes.
- Reset mid-command: send 0x81,0xAA, assert reset 1 cycle, then send 0x03 → no execute for 0x81; execute(0x03, 0).
- Timeout (CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16): send 0x82,0x01, idle 20 cycles → timeout_err pulse, no execute, cmd_pending=0. Then 0x05 → execute(0x05, 0).
- Boundary (CMD_TIMEOUT_EN): a byte arrives in the cycle the counter hits 15 → no timeout, and the command completes normally.
